// File: rtl/counter_pkg.sv
// Shared definitions for the prescaled up/down counter: direction/mode encodings
// and the single-step next-count function used by the datapath.
package counter_pkg;

    localparam logic DIR_UP    = 1'b1;
    localparam logic DIR_DOWN  = 1'b0;
    localparam logic MODE_WRAP = 1'b0;
    localparam logic MODE_SAT  = 1'b1;

    localparam int MAX_WIDTH = 32;

    typedef struct packed {
        logic [MAX_WIDTH-1:0] value;
        logic                 boundary;
    } step_result_t;

    // Operands are zero-extended counts; callers keep only their own WIDTH bits.
    // count+1 only happens below max_val and count-1 only above zero, so the
    // result never leaves the caller's range.
    function automatic step_result_t next_count(
        input logic [MAX_WIDTH-1:0] count,
        input logic                 dir,
        input logic                 sat,
        input logic [MAX_WIDTH-1:0] max_val
    );
        step_result_t res;
        res.value    = count;
        res.boundary = 1'b0;
        if (dir == DIR_UP) begin
            if (count < max_val) begin
                res.value = count + 32'd1;
            end else begin
                res.boundary = 1'b1;
                res.value    = (sat == MODE_SAT) ? count : '0;
            end
        end else begin
            if (count != '0) begin
                res.value = count - 32'd1;
            end else begin
                res.boundary = 1'b1;
                res.value    = (sat == MODE_SAT) ? count : max_val;
            end
        end
        return res;
    endfunction

endpackage

// File: rtl/tick_prescaler.sv
// Enable-gated clock divider: asserts tick once every prescale+1 enabled cycles.
module tick_prescaler
    import counter_pkg::*;
#(
    parameter int PRESCALE_W = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  en,
    input  logic                  sync_clr,
    input  logic [PRESCALE_W-1:0] prescale,
    output logic                  tick
);

    logic [PRESCALE_W-1:0] r_div;
    logic                  w_at_limit;

    // >= rather than == so that lowering prescale below the current div
    // fires at once instead of running div all the way round.
    assign w_at_limit = (r_div >= prescale);
    assign tick       = en & w_at_limit;

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of block ordering.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_div <= '0;
        end else if (sync_clr) begin
            r_div <= '0;
        end else if (en) begin
            if (w_at_limit) begin
                r_div <= '0;
            end else begin
                r_div <= r_div + PRESCALE_W'(1);
            end
        end
    end

endmodule

// File: rtl/prescaled_updown_counter.sv
// Parametrised up/down counter with modulo limit, wrap/saturate, load/clear,
// prescaler, terminal-count pulse, compare match and sticky overflow.
module prescaled_updown_counter
    import counter_pkg::*;
#(
    parameter int WIDTH      = 8,
    parameter int PRESCALE_W = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  en,
    input  logic                  dir,
    input  logic                  mode_sat,
    input  logic                  clr,
    input  logic                  load,
    input  logic [WIDTH-1:0]      load_val,
    input  logic [WIDTH-1:0]      max_val,
    input  logic [PRESCALE_W-1:0] prescale,
    input  logic [WIDTH-1:0]      cmp_val,
    input  logic                  ovf_clr,
    output logic [WIDTH-1:0]      count,
    output logic                  tc,
    output logic                  match,
    output logic                  ovf_sticky
);

    logic [WIDTH-1:0] r_count;
    logic             r_tc;
    logic             r_ovf;

    logic             w_tick;
    logic             w_step_en;
    logic             w_boundary_step;
    step_result_t     w_step;

    tick_prescaler #(
        .PRESCALE_W (PRESCALE_W)
    ) u_prescaler (
        .clk      (clk),
        .rst_n    (rst_n),
        .en       (en),
        .sync_clr (clr | load),
        .prescale (prescale),
        .tick     (w_tick)
    );

    assign w_step = next_count(MAX_WIDTH'(r_count), dir, mode_sat, MAX_WIDTH'(max_val));

    generate
        if (WIDTH < MAX_WIDTH) begin : g_unused_hi
            logic w_unused_hi;
            assign w_unused_hi = ^w_step.value[MAX_WIDTH-1:WIDTH];
        end
    endgenerate

    // clr and load both pre-empt a step that would otherwise happen this edge.
    assign w_step_en       = w_tick & ~clr & ~load;
    assign w_boundary_step = w_step_en & w_step.boundary;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_count <= '0;
        end else if (clr) begin
            r_count <= '0;
        end else if (load) begin
            r_count <= load_val;
        end else if (w_tick) begin
            r_count <= w_step.value[WIDTH-1:0];
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_tc <= 1'b0;
        end else begin
            r_tc <= w_boundary_step;
        end
    end

    // Only reset and ovf_clr clear the flag; a boundary step on the same edge wins.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_ovf <= 1'b0;
        end else if (w_boundary_step) begin
            r_ovf <= 1'b1;
        end else if (ovf_clr) begin
            r_ovf <= 1'b0;
        end
    end

    assign count      = r_count;
    assign tc         = r_tc;
    assign ovf_sticky = r_ovf;
    assign match      = (r_count == cmp_val);

endmodule

// File: tb/tb_prescaled_updown_counter.sv
// Directed self-checking bench for prescaled_updown_counter (WIDTH=8, PRESCALE_W=4).
module tb_prescaled_updown_counter;

    logic       clk = 1'b0;
    logic       rst_n, en, dir, mode_sat, clr, load, ovf_clr;
    logic [7:0] load_val, max_val, cmp_val;
    logic [3:0] prescale;
    logic [7:0] count;
    logic       tc, match, ovf_sticky;

    int n_checks = 0;
    int n_fail   = 0;

    prescaled_updown_counter #(
        .WIDTH      (8),
        .PRESCALE_W (4)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .en         (en),
        .dir        (dir),
        .mode_sat   (mode_sat),
        .clr        (clr),
        .load       (load),
        .load_val   (load_val),
        .max_val    (max_val),
        .prescale   (prescale),
        .cmp_val    (cmp_val),
        .ovf_clr    (ovf_clr),
        .count      (count),
        .tc         (tc),
        .match      (match),
        .ovf_sticky (ovf_sticky)
    );

    always #5 clk = ~clk;

    // Advance one rising edge and settle just after it.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    initial begin
        rst_n = 1'b0; en = 1'b0; dir = 1'b1; mode_sat = 1'b0; clr = 1'b0;
        load = 1'b0; ovf_clr = 1'b0; load_val = 8'h00; max_val = 8'd255;
        cmp_val = 8'd7; prescale = 4'd0;

        // 1. reset and full 8-bit up count
        step(); step();
        check("rst_count", count, 0);
        check("rst_tc", tc, 0);
        check("rst_ovf", ovf_sticky, 0);
        check("rst_match", match, 0);
        rst_n = 1'b1; en = 1'b1;
        for (int i = 1; i <= 255; i++) begin
            step();
            check("up_count", count, i);
            check("up_tc", tc, 0);
            if (i == 7) check("up_match7", match, 1);
            if (i == 8) check("up_match8", match, 0);
        end
        step();
        check("up_wrap_count", count, 0);
        check("up_wrap_tc", tc, 1);
        check("up_wrap_ovf", ovf_sticky, 1);
        step();
        check("up_after_count", count, 1);
        check("up_after_tc", tc, 0);

        // 2. modulo 10 wrap, then down from 0
        max_val = 8'd9; clr = 1'b1; ovf_clr = 1'b1;
        step();
        clr = 1'b0; ovf_clr = 1'b0;
        check("mod_clr_count", count, 0);
        check("mod_clr_ovf", ovf_sticky, 0);
        for (int j = 1; j <= 24; j++) begin
            step();
            check("mod_count", count, j % 10);
            check("mod_tc", tc, (j % 10 == 0) ? 1 : 0);
        end
        clr = 1'b1;
        step();
        clr = 1'b0; dir = 1'b0;
        step();
        check("dn_wrap_count", count, 9);
        check("dn_wrap_tc", tc, 1);
        step();
        check("dn_count8", count, 8);
        check("dn_tc8", tc, 0);
        step();
        check("dn_count7", count, 7);
        check("dn_match7", match, 1);

        // 3. saturate mode
        mode_sat = 1'b1; max_val = 8'd5; dir = 1'b1; clr = 1'b1;
        step();
        clr = 1'b0;
        for (int j = 1; j <= 10; j++) begin
            step();
            check("sat_up_count", count, (j < 5) ? j : 5);
            check("sat_up_tc", tc, (j >= 6) ? 1 : 0);
        end
        dir = 1'b0;
        for (int j = 1; j <= 6; j++) begin
            step();
            check("sat_dn_count", count, (j < 5) ? 5 - j : 0);
            check("sat_dn_tc", tc, (j == 6) ? 1 : 0);
        end

        // max_val = 0, wrap up: boundary on every tick
        mode_sat = 1'b0; max_val = 8'd0; dir = 1'b1;
        step();
        check("max0_count", count, 0);
        check("max0_tc", tc, 1);
        step();
        check("max0_tc2", tc, 1);

        // 4. prescaler with en gap mid-period
        max_val = 8'd9; prescale = 4'd3; clr = 1'b1;
        step();
        clr = 1'b0;
        step(); check("ps_e1", count, 0);
        step(); check("ps_e2", count, 0);
        en = 1'b0;
        step(); check("ps_hold1", count, 0);
        step(); check("ps_hold2", count, 0);
        en = 1'b1;
        step(); check("ps_e3", count, 0);
        step(); check("ps_e4", count, 1);
        step(); step(); step();
        check("ps_e7", count, 1);
        step(); check("ps_e8", count, 2);

        // 5. clr beats load; load above max_val then wrap
        prescale = 4'd0; clr = 1'b1; load = 1'b1; load_val = 8'h3C;
        step();
        check("prio_clr_count", count, 0);
        clr = 1'b0;
        step();
        check("prio_load_count", count, 8'h3C);
        check("prio_load_tc", tc, 0);
        load = 1'b0;
        step();
        check("prio_wrap_count", count, 0);
        check("prio_wrap_tc", tc, 1);

        // 6. sticky flag, match, reset mid-count
        load = 1'b1; load_val = 8'd9; ovf_clr = 1'b1;
        step();
        load = 1'b0;
        check("ovf_cleared", ovf_sticky, 0);
        check("ovf_load_count", count, 9);
        step();
        check("ovf_set_wins", ovf_sticky, 1);
        check("ovf_set_count", count, 0);
        step();
        ovf_clr = 1'b0;
        check("ovf_clr_only", ovf_sticky, 0);
        check("ovf_clr_count", count, 1);
        for (int j = 2; j <= 9; j++) begin
            step();
            check("m_count", count, j);
            check("m_match", match, (j == 7) ? 1 : 0);
        end
        step();
        step(); step(); step();
        check("pre_rst_count", count, 3);
        check("pre_rst_ovf", ovf_sticky, 1);
        rst_n = 1'b0;
        step();
        check("mid_rst_count", count, 0);
        check("mid_rst_tc", tc, 0);
        check("mid_rst_ovf", ovf_sticky, 0);
        check("mid_rst_match", match, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/prescaled_updown_counter.md
Name: prescaled_updown_counter

Overview:
Parametrised general-purpose counter that extends the free-running 8-bit counter block.
- Adds configurable width, up/down direction, programmable modulo limit, wrap or saturate mode, synchronous load and clear, and a clock prescaler.
- Outputs a terminal-count pulse, a compare match and a sticky overflow flag.
- Sits behind the tile top-level IO mapping as the reusable timing/counting primitive for the project.

Parameters:
- WIDTH, 8, bit width of count, load_val, max_val, cmp_val (legal 2..32).
- PRESCALE_W, 4, bit width of the prescale divider setting (legal 1..16).

Ports:
- clk  in  1  single clock; all state updates on its rising edge.
- rst_n  in  1  reset, synchronous, active-low.
- en  in  1  count enable; gates both the prescaler and count stepping.
- dir  in  1  1 = count up, 0 = count down.
- mode_sat  in  1  1 = saturate at boundary, 0 = wrap.
- clr  in  1  synchronous clear of count and prescaler.
- load  in  1  synchronous load of load_val.
- load_val  in  WIDTH  value written on load.
- max_val  in  WIDTH  modulo upper limit (inclusive).
- prescale  in  PRESCALE_W  step occurs every prescale+1 enabled cycles.
- cmp_val  in  WIDTH  compare value.
- ovf_clr  in  1  clears ovf_sticky.
- count  out  WIDTH  current count (registered).
- tc  out  1  registered one-cycle terminal-count pulse.
- match  out  1  combinational: count == cmp_val.
- ovf_sticky  out  1  registered sticky boundary-event flag.

Behaviour:
- Reset (rst_n=0 at edge): count=0, prescaler div=0, tc=0, ovf_sticky=0. Reset overrides every other input.
- Priority per edge, highest first: rst_n, clr, load, step.
  - clr: count=0, div=0, tc=0.
  - load: count=load_val, div=0, tc=0. Any load_val is accepted, including load_val > max_val.
- Prescaler, in sub-module tick_prescaler:
  - With en=1, div increments each cycle.
  - When div == prescale, tick=1 combinationally that cycle and div returns to 0 at the edge.
  - prescale=0 gives a tick on every enabled cycle.
  - en=0 freezes div; tick=0.
  - A change of prescale mid-count takes effect on the next compare. If div > prescale, tick fires immediately and div returns to 0.
- Step, when tick=1 and neither clr nor load is active:
  - Up, count < max_val: count+1.
  - Up, count >= max_val (boundary): wrap gives count=0; saturate holds count.
  - Down, count != 0: count-1.
  - Down, count == 0 (boundary): wrap gives count=max_val; saturate holds count.
  - All arithmetic is modulo 2^WIDTH. The max_val compare is unsigned.
- tc is 1 in the cycle after any edge that handled a boundary step, in either mode. Otherwise tc=0.
  - In saturate mode held at the boundary, tc pulses on every tick.
- ovf_sticky:
  - Set on the edge where a boundary step is handled.
  - Cleared by ovf_clr.
  - Set wins over a simultaneous ovf_clr.
  - clr and load do not affect it. Only reset and ovf_clr clear it.
- match follows count with zero latency. It is valid in every cycle, including reset.
- max_val=0:
  - Up wraps or holds at 0 every tick, with tc every tick.
  - Down is at the boundary every tick.
- Latency from a load/clr edge to a new count value is 1 cycle. The first tick after load/clr comes after prescale+1 enabled cycles.

Decomposition:
- Shared package counter_pkg holds:
  - DIR_UP=1 and DIR_DOWN=0.
  - MODE_WRAP=0 and MODE_SAT=1.
  - A function next_count(count, dir, sat, max_val) returning the stepped value and a boundary flag. This function is reused by the verification model.
- One sub-module, tick_prescaler, parametrised by PRESCALE_W.
  - Ports: clk, rst_n, en, sync_clr, prescale, tick.

Test Plan:
1. Reset and basic up count: rst_n low 2 cycles, then en=1, dir=1, prescale=0, max_val=255, wrap.
   -> count 0,1,2,…,255,0; tc high exactly the cycle count returns to 0; ovf_sticky=1 afterwards.
2. Modulo wrap: max_val=9, up, wrap, 25 ticks -> count 0..9,0..9,0..4; tc two pulses. Then dir=0 from count=0 -> count 9,8,…
3. Saturate: mode_sat=1, max_val=5, up 10 ticks -> count sticks at 5 and tc pulses on ticks 6..10. Then dir=0 -> 4,3,2,1,0,0; tc on each tick at 0.
4. Prescaler: prescale=3, en toggled low 2 cycles mid-period -> count steps every 4 enabled cycles; count and div frozen while en=0.
5. Priority: clr=1 and load=1 (load_val=0x3C) same cycle -> count=0. Next cycle load only -> count=0x3C, above max_val=9. One up tick -> count wraps to 0, tc=1.
6. Sticky flag: boundary step and ovf_clr in the same cycle -> ovf_sticky stays 1. ovf_clr the next cycle with no event -> 0. match=1 exactly when count==cmp_val=7. rst_n low mid-count -> all outputs 0 next cycle.
